sampler_stream_bridge: RTL and testbench

- Parametrised successor to the fixed 64-bit DMA<->CODEC stream path in the sampler top level.
- Buffers playback audio from AXI4-Stream (DMA -> CODEC) and capture audio to AXI4-Stream (CODEC -> DMA).
- Generalised in channel count, sample width and FIFO depth.
- Adds a programmable almost-empty threshold, underrun/overflow accounting and periodic tlast framing on the capture stream.
- Sits between the DMA AXI-Stream ports and the I2S serializer, which must already be synchronised to axis_aclk.

---
 rtl/sampler_stream_bridge.sv | 245 ++++++++++++++++++++++++
 tb/tb_sampler_stream_bridge.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_stream_bridge.sv
// -----------------------------------------------------------------------------
// sampler_stream_bridge
//
// Bidirectional audio buffer between the DMA AXI4-Stream ports and the I2S
// serializer. The serializer must already be synchronous to axis_aclk.
//
//   Playback : s_axis_* (DMA) -> playback FIFO -> pb_req/pb_valid/pb_data
//   Capture  : rec_valid/rec_data -> capture FIFO -> m_axis_* (DMA)
//
// Ports
//   axis_aclk, axis_aresetn      clock, synchronous active-low reset
//   s_axis_tvalid/tready/tdata   playback stream in (ch0 in the LSBs)
//   pb_req                       serializer pulse: fetch next frame
//   pb_valid, pb_data            frame returned one cycle after pb_req
//   ae_thresh                    almost-empty threshold (in frames)
//   DOWNSTREAM_almost_empty      registered (pb_level <= ae_thresh)
//   pb_level                     playback FIFO occupancy
//   rec_valid, rec_data, cap_en  captured frames from the serializer
//   m_axis_tvalid/tready/tdata   capture stream out
//   m_axis_tlast                 last beat of each FRAME_LEN-beat packet
//   cnt_clear                    clears counters and sticky flags
//   underrun_cnt, pb_underrun    saturating underrun count + sticky flag
//   overflow_cnt, cap_overflow   saturating dropped-frame count + sticky flag
//
// Build option
//   SAMPLER_HOLD_LAST_EN  when defined, a playback underrun repeats the last
//                         successfully popped frame instead of outputting 0.
// -----------------------------------------------------------------------------
module sampler_stream_bridge #(
    parameter int NUM_CH    = 2,
    parameter int SAMPLE_W  = 32,
    parameter int PB_DEPTH  = 512,
    parameter int CAP_DEPTH = 512,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic                          axis_aclk,
    input  logic                          axis_aresetn,

    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [NUM_CH*SAMPLE_W-1:0]    s_axis_tdata,

    input  logic                          pb_req,
    output logic                          pb_valid,
    output logic [NUM_CH*SAMPLE_W-1:0]    pb_data,

    input  logic [$clog2(PB_DEPTH):0]     ae_thresh,
    output logic                          DOWNSTREAM_almost_empty,
    output logic [$clog2(PB_DEPTH):0]     pb_level,

    input  logic                          rec_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]    rec_data,
    input  logic                          cap_en,

    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [NUM_CH*SAMPLE_W-1:0]    m_axis_tdata,
    output logic                          m_axis_tlast,

    input  logic                          cnt_clear,
    output logic [CNT_W-1:0]              underrun_cnt,
    output logic [CNT_W-1:0]              overflow_cnt,
    output logic                          pb_underrun,
    output logic                          cap_overflow
);

    localparam int DATA_W = NUM_CH * SAMPLE_W;
    localparam int PB_AW  = $clog2(PB_DEPTH);
    localparam int PB_LW  = PB_AW + 1;
    localparam int CAP_AW = $clog2(CAP_DEPTH);
    localparam int CAP_LW = CAP_AW + 1;
    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [PB_LW-1:0]  PB_FULL_LVL  = PB_LW'(PB_DEPTH);
    localparam logic [CAP_LW-1:0] CAP_FULL_LVL = CAP_LW'(CAP_DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST    = BEAT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    // =========================================================================
    // Playback FIFO
    // =========================================================================
    // Pointers carry one extra wrap bit so that wr - rd yields the exact
    // occupancy, letting every slot be used (full and empty are unambiguous).
    logic [DATA_W-1:0] pb_mem [PB_DEPTH];
    logic [PB_LW-1:0]  pb_wr_ptr;
    logic [PB_LW-1:0]  pb_rd_ptr;
    logic              pb_push;
    logic              pb_pop;
    logic              pb_underrun_evt;

    assign pb_level        = pb_wr_ptr - pb_rd_ptr;
    assign s_axis_tready   = (pb_level != PB_FULL_LVL);
    assign pb_push         = s_axis_tvalid && s_axis_tready;
    // The request is judged against the registered occupancy, so a write in
    // the same cycle cannot rescue a request made against an empty FIFO.
    assign pb_pop          = pb_req && (pb_level != '0);
    assign pb_underrun_evt = pb_req && (pb_level == '0);

    // NOTE: FIFO storage is deliberately left out of reset; the pointers alone
    // define which entries are valid, and an unreset array maps to plain RAM.
    always_ff @(posedge axis_aclk) begin
        if (pb_push) begin
            pb_mem[pb_wr_ptr[PB_AW-1:0]] <= s_axis_tdata;
        end
    end

    // NOTE: every register below is updated with <= so that all state moves
    // together on the edge and the order of statements never matters.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            pb_wr_ptr               <= '0;
            pb_rd_ptr               <= '0;
            pb_valid                <= 1'b0;
            pb_data                 <= '0;
            DOWNSTREAM_almost_empty <= 1'b1;
        end else begin
            if (pb_push) begin
                pb_wr_ptr <= pb_wr_ptr + PB_LW'(1);
            end

            pb_valid <= pb_req;
            if (pb_pop) begin
                pb_data   <= pb_mem[pb_rd_ptr[PB_AW-1:0]];
                pb_rd_ptr <= pb_rd_ptr + PB_LW'(1);
            end else if (pb_underrun_evt) begin
`ifdef SAMPLER_HOLD_LAST_EN
                // pb_data only ever changes on a successful pop (or reset to
                // zero), so leaving it alone repeats the last popped frame.
                pb_data <= pb_data;
`else
                pb_data <= '0;
`endif
            end

            // Compares the level as it stands now, so the flag trails a level
            // change by one cycle.
            DOWNSTREAM_almost_empty <= (pb_level <= ae_thresh);
        end
    end

    // =========================================================================
    // Capture FIFO with first-word-fall-through output register
    // =========================================================================
    // The output register is a copy of the FIFO head; the entry is only
    // released on the handshake. The register therefore adds no extra storage
    // and the capture path holds exactly CAP_DEPTH frames.
    logic [DATA_W-1:0] cap_mem [CAP_DEPTH];
    logic [CAP_LW-1:0] cap_wr_ptr;
    logic [CAP_LW-1:0] cap_rd_ptr;
    logic [CAP_LW-1:0] cap_level;
    logic [CAP_LW-1:0] cap_rd_sel;
    logic              cap_full;
    logic              cap_push;
    logic              cap_drop;
    logic              cap_hs;
    logic              cap_load;
    logic [BEAT_W-1:0] beat_cnt;

    assign cap_level = cap_wr_ptr - cap_rd_ptr;
    assign cap_full  = (cap_level == CAP_FULL_LVL);
    assign cap_push  = cap_en && rec_valid && !cap_full;
    assign cap_drop  = cap_en && rec_valid && cap_full;
    assign cap_hs    = m_axis_tvalid && m_axis_tready;

    // On a handshake the current head is leaving, so the next one to present
    // is the entry after it, provided one is already stored. With an empty
    // output register the current head is presented directly.
    assign cap_rd_sel = cap_hs ? (cap_rd_ptr + CAP_LW'(1)) : cap_rd_ptr;
    assign cap_load   = cap_hs ? (cap_level > CAP_LW'(1))
                               : (!m_axis_tvalid && (cap_level != '0));

    assign m_axis_tlast = m_axis_tvalid && (beat_cnt == BEAT_LAST);

    always_ff @(posedge axis_aclk) begin
        if (cap_push) begin
            cap_mem[cap_wr_ptr[CAP_AW-1:0]] <= rec_data;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            cap_wr_ptr    <= '0;
            cap_rd_ptr    <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            beat_cnt      <= '0;
        end else begin
            if (cap_push) begin
                cap_wr_ptr <= cap_wr_ptr + CAP_LW'(1);
            end

            if (cap_hs) begin
                cap_rd_ptr <= cap_rd_ptr + CAP_LW'(1);
                beat_cnt   <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
            end

            if (cap_load) begin
                m_axis_tdata  <= cap_mem[cap_rd_sel[CAP_AW-1:0]];
                m_axis_tvalid <= 1'b1;
            end else if (cap_hs) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // =========================================================================
    // Event accounting
    // =========================================================================
    // An event coinciding with cnt_clear wins: the count restarts at 1 and the
    // flag stays set, so no event is ever lost to a clear.
    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            underrun_cnt <= '0;
            pb_underrun  <= 1'b0;
            overflow_cnt <= '0;
            cap_overflow <= 1'b0;
        end else begin
            if (pb_underrun_evt) begin
                pb_underrun <= 1'b1;
                if (cnt_clear) begin
                    underrun_cnt <= CNT_W'(1);
                end else if (underrun_cnt != CNT_MAX) begin
                    underrun_cnt <= underrun_cnt + CNT_W'(1);
                end
            end else if (cnt_clear) begin
                underrun_cnt <= '0;
                pb_underrun  <= 1'b0;
            end

            if (cap_drop) begin
                cap_overflow <= 1'b1;
                if (cnt_clear) begin
                    overflow_cnt <= CNT_W'(1);
                end else if (overflow_cnt != CNT_MAX) begin
                    overflow_cnt <= overflow_cnt + CNT_W'(1);
                end
            end else if (cnt_clear) begin
                overflow_cnt <= '0;
                cap_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sampler_stream_bridge.sv
module tb_sampler_stream_bridge;

    localparam int NUM_CH    = 2;
    localparam int SAMPLE_W  = 32;
    localparam int PB_DEPTH  = 512;
    localparam int CAP_DEPTH = 4;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 16;
    localparam int DW        = NUM_CH * SAMPLE_W;
    localparam int LW        = $clog2(PB_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          pb_req;
    logic          pb_valid;
    logic [DW-1:0] pb_data;
    logic [LW-1:0] ae_thresh;
    logic          almost_empty;
    logic [LW-1:0] pb_level;
    logic          rec_valid;
    logic [DW-1:0] rec_data;
    logic          cap_en;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          cnt_clear;
    logic [CNT_W-1:0] underrun_cnt;
    logic [CNT_W-1:0] overflow_cnt;
    logic          pb_underrun;
    logic          cap_overflow;

    int total = 0;
    int bad   = 0;
    int beat_no = 0;  // capture beats accepted since reset, 1-based per beat

    always #5 clk = ~clk;

    sampler_stream_bridge #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PB_DEPTH(PB_DEPTH),
        .CAP_DEPTH(CAP_DEPTH), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)
    ) dut (
        .axis_aclk(clk),
        .axis_aresetn(rst_n),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .pb_req(pb_req),
        .pb_valid(pb_valid),
        .pb_data(pb_data),
        .ae_thresh(ae_thresh),
        .DOWNSTREAM_almost_empty(almost_empty),
        .pb_level(pb_level),
        .rec_valid(rec_valid),
        .rec_data(rec_data),
        .cap_en(cap_en),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .cnt_clear(cnt_clear),
        .underrun_cnt(underrun_cnt),
        .overflow_cnt(overflow_cnt),
        .pb_underrun(pb_underrun),
        .cap_overflow(cap_overflow)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pb_write(input logic [DW-1:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; pb_req = 1'b0;
        ae_thresh = '0; rec_valid = 1'b0; rec_data = '0; cap_en = 1'b0;
        m_axis_tready = 1'b0; cnt_clear = 1'b0;
        tick(); tick();
        if (pb_valid !== 1'b0 || pb_data !== '0) begin
            $display("FAIL reset_pb: pb_valid=%b pb_data=%h want 0/0", pb_valid, pb_data); bad++;
        end
        total++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            $display("FAIL reset_cap: tvalid=%b tlast=%b want 0/0", m_axis_tvalid, m_axis_tlast); bad++;
        end
        total++;
        if (almost_empty !== 1'b1) begin
            $display("FAIL reset_ae: got %b want 1", almost_empty); bad++;
        end
        total++;
        if (pb_level !== '0 || s_axis_tready !== 1'b1) begin
            $display("FAIL reset_level: level=%0d tready=%b want 0/1", pb_level, s_axis_tready); bad++;
        end
        total++;
        if (underrun_cnt !== '0 || overflow_cnt !== '0 || pb_underrun !== 1'b0 || cap_overflow !== 1'b0) begin
            $display("FAIL reset_cnt: urun=%0d ovf=%0d flags=%b%b want all 0",
                     underrun_cnt, overflow_cnt, pb_underrun, cap_overflow); bad++;
        end
        total++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_playback();
        logic [DW-1:0] exp_d;
        for (int i = 1; i <= 4; i++) pb_write(DW'(i));
        if (pb_level !== LW'(4)) begin
            $display("FAIL pb_level4: got %0d want 4", pb_level); bad++;
        end
        total++;
        for (int i = 1; i <= 5; i++) begin
            exp_d = DW'(i);
            if (i == 5) begin
`ifdef SAMPLER_HOLD_LAST_EN
                exp_d = DW'(4);
`else
                exp_d = '0;
`endif
            end
            pb_req = 1'b1;
            tick();
            pb_req = 1'b0;
            if (pb_valid !== 1'b1 || pb_data !== exp_d) begin
                $display("FAIL pb_read%0d: valid=%b data=%h want 1/%h", i, pb_valid, pb_data, exp_d); bad++;
            end
            total++;
            tick();
            if (pb_valid !== 1'b0 || pb_data !== exp_d) begin
                $display("FAIL pb_hold%0d: valid=%b data=%h want 0/%h", i, pb_valid, pb_data, exp_d); bad++;
            end
            total++;
        end
        if (underrun_cnt !== CNT_W'(1) || pb_underrun !== 1'b1) begin
            $display("FAIL pb_underrun: cnt=%0d flag=%b want 1/1", underrun_cnt, pb_underrun); bad++;
        end
        total++;
    endtask

    task automatic test_almost_empty();
        ae_thresh = LW'(2);
        for (int i = 0; i < 4; i++) pb_write(DW'(16 + i));
        tick();
        if (almost_empty !== 1'b0) begin
            $display("FAIL ae_loaded: got %b want 0", almost_empty); bad++;
        end
        total++;
        // level 4 -> 3
        pb_req = 1'b1; tick(); pb_req = 1'b0;
        tick();
        if (pb_level !== LW'(3) || almost_empty !== 1'b0) begin
            $display("FAIL ae_lvl3: level=%0d ae=%b want 3/0", pb_level, almost_empty); bad++;
        end
        total++;
        // level 3 -> 2: flag follows one cycle later
        pb_req = 1'b1; tick(); pb_req = 1'b0;
        if (pb_level !== LW'(2) || almost_empty !== 1'b0 || pb_data !== DW'(17)) begin
            $display("FAIL ae_lvl2_now: level=%0d ae=%b data=%h want 2/0/11", pb_level, almost_empty, pb_data); bad++;
        end
        total++;
        tick();
        if (almost_empty !== 1'b1) begin
            $display("FAIL ae_lvl2_next: got %b want 1", almost_empty); bad++;
        end
        total++;
        pb_req = 1'b1; tick(); tick(); pb_req = 1'b0;
        if (pb_data !== DW'(19) || pb_level !== '0) begin
            $display("FAIL ae_drain: data=%h level=%0d want 13/0", pb_data, pb_level); bad++;
        end
        total++;
        // threshold 0: asserted only when empty
        ae_thresh = '0;
        pb_write(DW'(32'h55));
        tick();
        if (almost_empty !== 1'b0) begin
            $display("FAIL ae_zero_one: got %b want 0", almost_empty); bad++;
        end
        total++;
        pb_req = 1'b1; tick(); pb_req = 1'b0;
        tick();
        if (almost_empty !== 1'b1 || pb_data !== DW'(32'h55)) begin
            $display("FAIL ae_zero_empty: ae=%b data=%h want 1/55", almost_empty, pb_data); bad++;
        end
        total++;
    endtask

    task automatic test_full();
        ae_thresh = LW'(PB_DEPTH);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < PB_DEPTH; i++) begin
            s_axis_tdata = DW'(256 + i);
            tick();
        end
        s_axis_tdata = DW'(32'hBEEF);  // stays offered while full
        tick(); tick();
        if (pb_level !== LW'(PB_DEPTH) || s_axis_tready !== 1'b0) begin
            $display("FAIL full_state: level=%0d tready=%b want 512/0", pb_level, s_axis_tready); bad++;
        end
        total++;
        if (almost_empty !== 1'b1) begin
            $display("FAIL full_ae_max: got %b want 1", almost_empty); bad++;
        end
        total++;
        pb_req = 1'b1; tick(); pb_req = 1'b0;
        if (s_axis_tready !== 1'b1 || pb_level !== LW'(PB_DEPTH - 1) || pb_data !== DW'(256)) begin
            $display("FAIL full_pop: tready=%b level=%0d data=%h want 1/511/100",
                     s_axis_tready, pb_level, pb_data); bad++;
        end
        total++;
        tick();
        s_axis_tvalid = 1'b0;
        if (pb_level !== LW'(PB_DEPTH)) begin
            $display("FAIL full_refill: level=%0d want 512", pb_level); bad++;
        end
        total++;
        pb_req = 1'b1;
        for (int i = 1; i <= PB_DEPTH; i++) begin
            logic [DW-1:0] exp_d;
            exp_d = (i == PB_DEPTH) ? DW'(32'hBEEF) : DW'(256 + i);
            tick();
            if (pb_data !== exp_d) begin
                $display("FAIL full_drain%0d: got %h want %h", i, pb_data, exp_d); bad++;
            end
            total++;
        end
        pb_req = 1'b0;
        tick();
        if (pb_level !== '0 || underrun_cnt !== CNT_W'(1)) begin
            $display("FAIL full_end: level=%0d urun=%0d want 0/1", pb_level, underrun_cnt); bad++;
        end
        total++;
    endtask

    task automatic test_framing();
        int sent = 0;
        int got  = 0;
        logic [15:0] bp;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        cap_en = 1'b1;
        m_axis_tready = 1'b1;
        for (int step = 0; step < 40; step++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                got++; beat_no++;
                if (m_axis_tdata !== DW'(got) || m_axis_tlast !== (beat_no % FRAME_LEN == 0)) begin
                    $display("FAIL frame_beat%0d: data=%h last=%b want %h/%b", got, m_axis_tdata,
                             m_axis_tlast, DW'(got), (beat_no % FRAME_LEN == 0)); bad++;
                end
                total++;
            end
            if (sent < 10 && step % 2 == 0) begin
                sent++; rec_valid = 1'b1; rec_data = DW'(sent);
            end else begin
                rec_valid = 1'b0;
            end
            tick();
        end
        if (got !== 10) begin
            $display("FAIL frame_count: got %0d want 10", got); bad++;
        end
        total++;

        // Same path under a fixed backpressure pattern.
        bp = 16'b1011_0110_1101_0011;
        sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int step = 0; step < 80; step++) begin
            m_axis_tready = bp[step % 16];
            if (prev_stall) begin
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    $display("FAIL bp_stable%0d: valid=%b data=%h last=%b want 1/%h/%b", step,
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last); bad++;
                end
                total++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got++; beat_no++;
                if (m_axis_tdata !== DW'(48 + got) || m_axis_tlast !== (beat_no % FRAME_LEN == 0)) begin
                    $display("FAIL bp_beat%0d: data=%h last=%b want %h/%b", got, m_axis_tdata,
                             m_axis_tlast, DW'(48 + got), (beat_no % FRAME_LEN == 0)); bad++;
                end
                total++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (sent < 8 && step % 3 == 0) begin
                sent++; rec_valid = 1'b1; rec_data = DW'(48 + sent);
            end else begin
                rec_valid = 1'b0;
            end
            tick();
        end
        rec_valid = 1'b0;
        if (got !== 8 || overflow_cnt !== '0) begin
            $display("FAIL bp_count: beats=%0d ovf=%0d want 8/0", got, overflow_cnt); bad++;
        end
        total++;
    endtask

    task automatic test_overflow();
        int got = 0;
        m_axis_tready = 1'b0;
        cap_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            rec_valid = 1'b1; rec_data = DW'(32 + k);
            tick();
        end
        rec_valid = 1'b0;
        tick();
        if (overflow_cnt !== CNT_W'(2) || cap_overflow !== 1'b1) begin
            $display("FAIL ovf_count: cnt=%0d flag=%b want 2/1", overflow_cnt, cap_overflow); bad++;
        end
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(33)) begin
            $display("FAIL ovf_head: valid=%b data=%h want 1/21", m_axis_tvalid, m_axis_tdata); bad++;
        end
        total++;
        // With capture disabled a further frame is neither stored nor counted.
        cap_en = 1'b0;
        rec_valid = 1'b1; rec_data = DW'(32'h99);
        tick();
        rec_valid = 1'b0;
        if (overflow_cnt !== CNT_W'(2)) begin
            $display("FAIL ovf_capdis: cnt=%0d want 2", overflow_cnt); bad++;
        end
        total++;
        m_axis_tready = 1'b1;
        for (int step = 0; step < 20; step++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                got++; beat_no++;
                if (m_axis_tdata !== DW'(32 + got) || m_axis_tlast !== (beat_no % FRAME_LEN == 0)) begin
                    $display("FAIL ovf_drain%0d: data=%h last=%b want %h/%b", got, m_axis_tdata,
                             m_axis_tlast, DW'(32 + got), (beat_no % FRAME_LEN == 0)); bad++;
                end
                total++;
            end
            tick();
        end
        if (got !== 4) begin
            $display("FAIL ovf_drain_count: got %0d want 4", got); bad++;
        end
        total++;
    endtask

    task automatic test_cnt_clear();
        for (int i = 0; i < 4; i++) begin
            pb_req = 1'b1; tick(); pb_req = 1'b0; tick();
        end
        if (underrun_cnt !== CNT_W'(5)) begin
            $display("FAIL clr_pre: cnt=%0d want 5", underrun_cnt); bad++;
        end
        total++;
        pb_req = 1'b1; cnt_clear = 1'b1;
        tick();
        pb_req = 1'b0; cnt_clear = 1'b0;
        if (underrun_cnt !== CNT_W'(1) || pb_underrun !== 1'b1) begin
            $display("FAIL clr_event_wins: cnt=%0d flag=%b want 1/1", underrun_cnt, pb_underrun); bad++;
        end
        total++;
        if (overflow_cnt !== '0 || cap_overflow !== 1'b0) begin
            $display("FAIL clr_ovf: cnt=%0d flag=%b want 0/0", overflow_cnt, cap_overflow); bad++;
        end
        total++;
        tick();
        cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
        if (underrun_cnt !== '0 || pb_underrun !== 1'b0) begin
            $display("FAIL clr_alone: cnt=%0d flag=%b want 0/0", underrun_cnt, pb_underrun); bad++;
        end
        total++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) pb_write(DW'(32'h70 + i));
        m_axis_tready = 1'b0; cap_en = 1'b1;
        rec_valid = 1'b1; rec_data = DW'(32'h80); tick();
        rec_data = DW'(32'h81); tick();
        rec_valid = 1'b0; tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        if (pb_level !== '0 || m_axis_tvalid !== 1'b0 || almost_empty !== 1'b1) begin
            $display("FAIL mid_reset: level=%0d tvalid=%b ae=%b want 0/0/1",
                     pb_level, m_axis_tvalid, almost_empty); bad++;
        end
        total++;
        m_axis_tready = 1'b1;
        tick(); tick();
        if (m_axis_tvalid !== 1'b0) begin
            $display("FAIL mid_reset_cap: tvalid=%b want 0", m_axis_tvalid); bad++;
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_playback();
        test_almost_empty();
        test_full();
        test_framing();
        test_overflow();
        test_cnt_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
